// File: rtl/ysyx_23060332_mem_arb_if.sv
// Bus bundle for the memory arbiter: the fetch and load/store request
// channels, the single memory channel and the timeout error pulse.
//   slave  : the arbiter's view (takes requests, drives memory)
//   master : the environment's view (requesters plus memory model)
interface ysyx_23060332_mem_arb_if;
  // fetch side
  logic        ifu_req;
  logic [31:0] ifu_addr;
  logic        ifu_ready;
  logic        ifu_rvalid;
  logic [31:0] ifu_rdata;
  // load/store side
  logic        lsu_req;
  logic        lsu_wen;
  logic [31:0] lsu_addr;
  logic [31:0] lsu_wdata;
  logic [7:0]  lsu_wmask;
  logic        lsu_ready;
  logic        lsu_rvalid;
  logic [31:0] lsu_rdata;
  // memory side
  logic        mem_req;
  logic        mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [7:0]  mem_wmask;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  // error
  logic        err_timeout;

  modport slave (
    input  ifu_req, ifu_addr,
    output ifu_ready, ifu_rvalid, ifu_rdata,
    input  lsu_req, lsu_wen, lsu_addr, lsu_wdata, lsu_wmask,
    output lsu_ready, lsu_rvalid, lsu_rdata,
    output mem_req, mem_wen, mem_addr, mem_wdata, mem_wmask,
    input  mem_gnt, mem_rvalid, mem_rdata,
    output err_timeout
  );

  modport master (
    output ifu_req, ifu_addr,
    input  ifu_ready, ifu_rvalid, ifu_rdata,
    output lsu_req, lsu_wen, lsu_addr, lsu_wdata, lsu_wmask,
    input  lsu_ready, lsu_rvalid, lsu_rdata,
    input  mem_req, mem_wen, mem_addr, mem_wdata, mem_wmask,
    output mem_gnt, mem_rvalid, mem_rdata,
    input  err_timeout
  );
endinterface

// File: rtl/ysyx_23060332_mem_arb.sv
// Two-requester memory arbiter (fetch + load/store) with one outstanding
// transaction, round-robin arbitration and a response timeout.
//   clk   : system clock, all state updates on the rising edge
//   rst_n : synchronous active-low reset
//   bus   : ysyx_23060332_mem_arb_if.slave -- ifu_*, lsu_*, mem_*, err_timeout
// Flow: IDLE accepts one winner (ready for one cycle) -> REQ holds mem_req
// until mem_gnt -> RESP waits for mem_rvalid, or synthesises an error
// response (0xDEADBEEF + err_timeout) after 256 silent cycles.
module ysyx_23060332_mem_arb (
  input  logic                           clk,
  input  logic                           rst_n,
  ysyx_23060332_mem_arb_if.slave         bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

  state_t      state, state_nxt;
  logic        ptr_lsu;       // 1: LSU wins a tie on the next accept
  logic        own_lsu;       // owner of the outstanding transaction
  logic        lat_wen;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [7:0]  lat_wmask;
  logic [7:0]  tmo_cnt;
  logic        tmo_expired;   // counter sat at 255 through a silent cycle

  logic any_req;
  logic grant_lsu;

  assign any_req   = bus.ifu_req | bus.lsu_req;
  assign grant_lsu = bus.lsu_req & (~bus.ifu_req | ptr_lsu);

  // State register
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    // NOTE: default assignment first so no path leaves state_nxt unassigned
    // (which would infer a latch).
    state_nxt = state;
    case (state)
      IDLE:    if (any_req)     state_nxt = REQ;
      REQ:     if (bus.mem_gnt) state_nxt = RESP;
      RESP:    if (bus.mem_rvalid || tmo_expired) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request latches, round-robin pointer and timeout counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_lsu     <= 1'b1;
      own_lsu     <= 1'b0;
      lat_wen     <= 1'b0;
      lat_addr    <= '0;
      lat_wdata   <= '0;
      lat_wmask   <= '0;
      tmo_cnt     <= '0;
      tmo_expired <= 1'b0;
    end else begin
      // Latch only on acceptance; later input changes are ignored.
      if (state == IDLE && any_req) begin
        own_lsu   <= grant_lsu;
        ptr_lsu   <= ~grant_lsu;
        lat_addr  <= grant_lsu ? bus.lsu_addr : bus.ifu_addr;
        lat_wen   <= grant_lsu & bus.lsu_wen;
        lat_wdata <= grant_lsu ? bus.lsu_wdata : '0;
        // Reads (fetch or load) never carry a byte mask to memory.
        lat_wmask <= (grant_lsu && bus.lsu_wen) ? bus.lsu_wmask : '0;
      end
      if (state == REQ && bus.mem_gnt) begin
        tmo_cnt     <= '0;
        tmo_expired <= 1'b0;
      end
      // Count silent RESP cycles; saturate at 255 and flag expiry so the
      // error response comes one cycle after the counter reached 255.
      if (state == RESP && !bus.mem_rvalid) begin
        if (tmo_cnt == 8'hFF) tmo_expired <= 1'b1;
        else                  tmo_cnt     <= tmo_cnt + 8'd1;
      end
    end
  end

  // Outputs (gated by rst_n so a reset cycle shows all zeros, even mid-RESP)
  always_comb begin
    bus.ifu_ready   = 1'b0;
    bus.ifu_rvalid  = 1'b0;
    bus.ifu_rdata   = '0;
    bus.lsu_ready   = 1'b0;
    bus.lsu_rvalid  = 1'b0;
    bus.lsu_rdata   = '0;
    bus.mem_req     = 1'b0;
    bus.mem_wen     = 1'b0;
    bus.mem_addr    = '0;
    bus.mem_wdata   = '0;
    bus.mem_wmask   = '0;
    bus.err_timeout = 1'b0;
    if (rst_n) begin
      case (state)
        IDLE: begin
          if (grant_lsu)        bus.lsu_ready = 1'b1;
          else if (bus.ifu_req) bus.ifu_ready = 1'b1;
        end
        REQ: begin
          bus.mem_req   = 1'b1;
          bus.mem_wen   = lat_wen;
          bus.mem_addr  = lat_addr;
          bus.mem_wdata = lat_wdata;
          bus.mem_wmask = lat_wmask;
        end
        RESP: begin
          // A real response beats a simultaneous timeout.
          if (bus.mem_rvalid || tmo_expired) begin
            bus.err_timeout = ~bus.mem_rvalid;
            if (own_lsu) begin
              bus.lsu_rvalid = 1'b1;
              bus.lsu_rdata  = bus.mem_rvalid ? bus.mem_rdata : TIMEOUT_DATA;
            end else begin
              bus.ifu_rvalid = 1'b1;
              bus.ifu_rdata  = bus.mem_rvalid ? bus.mem_rdata : TIMEOUT_DATA;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_23060332_mem_arb.sv
// Directed self-checking bench for ysyx_23060332_mem_arb. Expected
// responses are queued when a request is accepted and popped when the
// DUT raises an rvalid.
module tb_ysyx_23060332_mem_arb;

  typedef struct {
    logic        is_lsu;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  exp_t sb[$];
  bit   exp_order[3] = '{1'b1, 1'b0, 1'b1};

  ysyx_23060332_mem_arb_if bus ();

  ysyx_23060332_mem_arb dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock and land on the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.ifu_req    = 1'b0;
    bus.ifu_addr   = '0;
    bus.lsu_req    = 1'b0;
    bus.lsu_wen    = 1'b0;
    bus.lsu_addr   = '0;
    bus.lsu_wdata  = '0;
    bus.lsu_wmask  = '0;
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;
  endtask

  task automatic push_exp(input logic is_lsu, input logic [31:0] rdata, input logic err);
    exp_t e;
    e.is_lsu = is_lsu;
    e.rdata  = rdata;
    e.err    = err;
    sb.push_back(e);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctl"}, 32'({bus.ifu_ready, bus.ifu_rvalid, bus.lsu_ready, bus.lsu_rvalid,
                              bus.mem_req, bus.mem_wen, bus.err_timeout}), 32'd0);
    check({tag, "_ifu_rdata"}, bus.ifu_rdata, 32'd0);
    check({tag, "_lsu_rdata"}, bus.lsu_rdata, 32'd0);
    check({tag, "_mem_addr"},  bus.mem_addr, 32'd0);
    check({tag, "_mem_wdata"}, bus.mem_wdata, 32'd0);
    check({tag, "_mem_wmask"}, 32'(bus.mem_wmask), 32'd0);
  endtask

  // Pop the oldest expected response and compare against the DUT outputs.
  task automatic check_resp(input string tag);
    exp_t e;
    checks++;
    assert (sb.size() != 0) else begin
      errors++;
      $error("FAIL %s_sb observed=empty expected=pending", tag);
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check({tag, "_ifu_rvalid"}, 32'(bus.ifu_rvalid), 32'(!e.is_lsu));
      check({tag, "_lsu_rvalid"}, 32'(bus.lsu_rvalid), 32'(e.is_lsu));
      check({tag, "_owner_rdata"}, e.is_lsu ? bus.lsu_rdata : bus.ifu_rdata, e.rdata);
      check({tag, "_other_rdata"}, e.is_lsu ? bus.ifu_rdata : bus.lsu_rdata, 32'd0);
      check({tag, "_err"}, 32'(bus.err_timeout), 32'(e.err));
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    idle_inputs();

    // ---- reset: outputs stay 0 even with requests and rvalid present
    @(negedge clk);
    bus.ifu_req    = 1'b1;
    bus.lsu_req    = 1'b1;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'hFFFF_FFFF;
    #1 check_all_zero("reset");
    tick();
    idle_inputs();
    rst_n = 1'b1;
    #1 check_all_zero("idle_after_reset");

    // ---- IFU-only fetch: ready c0, mem_req c1, rvalid c2
    tick();
    bus.ifu_req  = 1'b1;
    bus.ifu_addr = 32'h8000_0000;
    #1;
    check("t1_ifu_ready", 32'(bus.ifu_ready), 32'd1);
    check("t1_lsu_ready", 32'(bus.lsu_ready), 32'd0);
    check("t1_c0_mem_req", 32'(bus.mem_req), 32'd0);
    push_exp(1'b0, 32'h0000_0413, 1'b0);
    tick();
    bus.ifu_req  = 1'b0;
    bus.ifu_addr = 32'h1234_5678;
    bus.mem_gnt  = 1'b1;
    #1;
    check("t1_c1_mem_req", 32'(bus.mem_req), 32'd1);
    check("t1_c1_mem_addr", bus.mem_addr, 32'h8000_0000);
    check("t1_c1_mem_wen_wmask", 32'({bus.mem_wen, bus.mem_wmask}), 32'd0);
    check("t1_c1_ifu_ready", 32'(bus.ifu_ready), 32'd0);
    tick();
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h0000_0413;
    #1 check_resp("t1_c2");
    // stray mem_rvalid in IDLE must be ignored
    tick();
    bus.mem_rdata = 32'hBAD0_BAD0;
    #1;
    check("t1_stray_rvalid", 32'({bus.ifu_rvalid, bus.lsu_rvalid}), 32'd0);
    check("t1_stray_ifu_rdata", bus.ifu_rdata, 32'd0);
    bus.mem_rvalid = 1'b0;

    // ---- round robin from reset: LSU, IFU, LSU (loads keep wmask 0)
    do_reset();
    bus.ifu_req   = 1'b1;
    bus.ifu_addr  = 32'h8000_0100;
    bus.lsu_req   = 1'b1;
    bus.lsu_wen   = 1'b0;
    bus.lsu_addr  = 32'h8000_0200;
    bus.lsu_wdata = 32'hAAAA_5555;
    bus.lsu_wmask = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("rr_lsu_ready", 32'(bus.lsu_ready), 32'(exp_order[i]));
      check("rr_ifu_ready", 32'(bus.ifu_ready), 32'(!exp_order[i]));
      push_exp(exp_order[i], 32'(32'h1000 + i), 1'b0);
      tick();
      bus.mem_gnt = 1'b1;
      #1;
      check("rr_mem_addr", bus.mem_addr, exp_order[i] ? 32'h8000_0200 : 32'h8000_0100);
      check("rr_mem_wen_wmask", 32'({bus.mem_wen, bus.mem_wmask}), 32'd0);
      check("rr_req_no_ready", 32'({bus.ifu_ready, bus.lsu_ready}), 32'd0);
      tick();
      bus.mem_gnt    = 1'b0;
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = 32'(32'h1000 + i);
      #1;
      check_resp("rr_resp");
      check("rr_resp_no_ready", 32'({bus.ifu_ready, bus.lsu_ready}), 32'd0);
      tick();
      bus.mem_rvalid = 1'b0;
    end
    bus.ifu_req = 1'b0;
    bus.lsu_req = 1'b0;

    // ---- LSU store with mem_gnt delayed 4 cycles
    bus.lsu_req   = 1'b1;
    bus.lsu_wen   = 1'b1;
    bus.lsu_addr  = 32'h8000_1000;
    bus.lsu_wdata = 32'h1234_5678;
    bus.lsu_wmask = 8'h0F;
    #1;
    check("st_lsu_ready", 32'(bus.lsu_ready), 32'd1);
    push_exp(1'b1, 32'hCAFE_0000, 1'b0);
    for (int c = 0; c < 5; c++) begin
      tick();
      if (c == 0) begin
        bus.lsu_req   = 1'b0;
        bus.lsu_wen   = 1'b0;
        bus.lsu_addr  = 32'hFFFF_FFFF;
        bus.lsu_wdata = 32'h0;
        bus.lsu_wmask = 8'hFF;
      end
      bus.mem_gnt    = (c == 4);
      bus.mem_rvalid = (c == 2);
      bus.mem_rdata  = 32'h0BAD_0BAD;
      #1;
      check("st_mem_req", 32'(bus.mem_req), 32'd1);
      check("st_mem_addr", bus.mem_addr, 32'h8000_1000);
      check("st_mem_wdata", bus.mem_wdata, 32'h1234_5678);
      check("st_mem_wen_wmask", 32'({bus.mem_wen, bus.mem_wmask}), 32'h10F);
      check("st_req_rvalid_ignored", 32'(bus.lsu_rvalid), 32'd0);
    end
    tick();
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'hCAFE_0000;
    #1;
    check_resp("st_resp");
    check("st_resp_mem_req", 32'(bus.mem_req), 32'd0);
    tick();
    bus.mem_rvalid = 1'b0;

    // ---- timeout: 256 silent RESP cycles then error response
    bus.ifu_req  = 1'b1;
    bus.ifu_addr = 32'h8000_2000;
    #1 check("to_ifu_ready", 32'(bus.ifu_ready), 32'd1);
    push_exp(1'b0, 32'hDEAD_BEEF, 1'b1);
    tick();
    bus.ifu_req = 1'b0;
    bus.mem_gnt = 1'b1;
    for (int k = 0; k < 256; k++) begin
      tick();
      bus.mem_gnt = 1'b0;
      #1 check("to_silent", 32'({bus.ifu_rvalid, bus.err_timeout}), 32'd0);
    end
    tick();
    #1 check_resp("to_fire");
    tick();
    bus.lsu_req  = 1'b1;
    bus.lsu_wen  = 1'b0;
    bus.lsu_addr = 32'h8000_3000;
    #1;
    check("to_idle_lsu_ready", 32'(bus.lsu_ready), 32'd1);
    check("to_idle_err", 32'(bus.err_timeout), 32'd0);
    push_exp(1'b1, 32'h5A5A_5A5A, 1'b0);
    tick();
    bus.lsu_req = 1'b0;
    bus.mem_gnt = 1'b1;
    for (int k = 0; k < 256; k++) begin
      tick();
      bus.mem_gnt = 1'b0;
      #1 check("race_silent", 32'({bus.lsu_rvalid, bus.err_timeout}), 32'd0);
    end
    tick();
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h5A5A_5A5A;
    #1 check_resp("race_rvalid_wins");
    tick();
    bus.mem_rvalid = 1'b0;

    // ---- reset during RESP abandons the transaction
    bus.ifu_req  = 1'b1;
    bus.ifu_addr = 32'h8000_4000;
    #1 check("rst_ifu_ready", 32'(bus.ifu_ready), 32'd1);
    tick();
    bus.ifu_req = 1'b0;
    bus.mem_gnt = 1'b1;
    tick();
    bus.mem_gnt = 1'b0;
    rst_n = 1'b0;
    #1 check_all_zero("rst_in_resp");
    tick();
    rst_n          = 1'b1;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h7777_7777;
    #1 check_all_zero("rst_late_rvalid");
    tick();
    bus.mem_rvalid = 1'b0;
    bus.ifu_req    = 1'b1;
    bus.lsu_req    = 1'b1;
    bus.lsu_addr   = 32'h8000_5000;
    #1;
    check("rst_next_lsu_ready", 32'(bus.lsu_ready), 32'd1);
    check("rst_next_ifu_ready", 32'(bus.ifu_ready), 32'd0);
    tick();
    idle_inputs();

    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL sb_drained observed=%0d expected=0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ysyx_23060332_mem_arb.md
YSYX_23060332_MEM_ARB -- requirements
Module: ysyx_23060332_mem_arb

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset:
  clk  in  1  system clock; all state updates on rising edge
  rst_n  in  1  synchronous active-low reset
REQ-002 The fetch-side ports SHALL be:
  ifu_req  in  1  fetch read request, held until accepted
  ifu_addr  in  32  fetch address
  ifu_ready  out  1  request accepted this cycle
  ifu_rvalid  out  1  fetch data valid, 1-cycle pulse
  ifu_rdata  out  32  fetch data
REQ-003 The load/store-side ports SHALL be:
  lsu_req  in  1  load/store request, held until accepted
  lsu_wen  in  1  1 = store, 0 = load
  lsu_addr  in  32  access address
  lsu_wdata  in  32  store data
  lsu_wmask  in  8  store byte mask
  lsu_ready  out  1  request accepted this cycle
  lsu_rvalid  out  1  completion pulse for load or store
  lsu_rdata  out  32  load data
REQ-004 The memory-side ports SHALL be:
  mem_req  out  1  request to memory
  mem_wen  out  1  write enable
  mem_addr  out  32  address
  mem_wdata  out  32  write data
  mem_wmask  out  8  byte mask
  mem_gnt  in  1  memory accepted mem_req
  mem_rvalid  in  1  response valid
  mem_rdata  in  32  response data
REQ-005 The error output SHALL be: err_timeout  out  1  1-cycle pulse on response timeout.

Function
REQ-006 The FSM SHALL have the states IDLE, REQ and RESP, with one outstanding transaction at most.
REQ-007 In IDLE with any request asserted, the block SHALL select one winner, assert that requester's ready for exactly that cycle, latch its addr/wen/wdata/wmask/owner, and go to REQ next cycle.
REQ-008 Arbitration SHALL be round-robin: when both request, the winner is the side not granted last. The priority pointer SHALL favour LSU after reset.
REQ-009 In REQ, mem_req SHALL be 1 and the mem_* outputs SHALL show the latched values. The block SHALL stay in REQ until mem_gnt=1, then go to RESP.
REQ-010 For an IFU owner, or an LSU load, the block SHALL drive mem_wen=0 and mem_wmask=0.
REQ-011 In RESP, when mem_rvalid=1, the block SHALL combinationally assert the owner's rvalid and present mem_rdata on the owner's rdata in that same cycle, then go to IDLE.
REQ-012 mem_rvalid SHALL be ignored outside RESP. The non-owner's rvalid SHALL stay 0.
REQ-013 Minimum latency SHALL be 2 cycles from ready to rvalid: accept in cycle 0, gnt in cycle 1, rvalid in cycle 2.
REQ-014 No new request SHALL be accepted until the cycle after the owner's rvalid, so back-to-back accepts are 3 cycles apart at minimum.
REQ-015 An 8-bit timeout counter SHALL clear on entry to RESP and increment each RESP cycle without mem_rvalid.
REQ-016 When the timeout counter reaches 255 without mem_rvalid, the block SHALL, in the next cycle, pulse err_timeout and the owner's rvalid with rdata=32'hDEADBEEF, then go to IDLE.
REQ-017 If mem_rvalid and the timeout fire in the same cycle, mem_rvalid SHALL win: normal data, no err_timeout.
REQ-018 rdata outputs SHALL be 0 whenever the matching rvalid is 0.
REQ-019 The request latches SHALL ignore changes on ifu_*/lsu_* inputs after acceptance.

Reset
REQ-020 While rst_n=0 at a clock edge, the block SHALL go to IDLE, clear the latches and timeout counter, set the pointer to LSU, and drive every output to 0.
REQ-021 A reset in REQ or RESP SHALL abandon the transaction: no rvalid, and any later mem_rvalid is ignored.

Verification
REQ-022 The bench SHALL cover: IFU-only read of addr 0x80000000, mem_gnt immediate, mem_rvalid next cycle with 0x00000413 -> ifu_ready at c0, mem_req at c1, ifu_rvalid=1 with ifu_rdata=0x00000413 at c2.
REQ-023 The bench SHALL cover: both requesters asserted on three consecutive accepts after reset -> grant order LSU, IFU, LSU.
REQ-024 The bench SHALL cover: LSU store addr 0x80001000, wdata 0x12345678, wmask 0x0F, with mem_gnt delayed 4 cycles -> mem_req held 5 cycles with stable fields, then lsu_rvalid pulse.
REQ-025 The bench SHALL cover: no mem_rvalid for 256 RESP cycles -> err_timeout and owner rvalid pulse together with rdata=0xDEADBEEF, then FSM in IDLE.
REQ-026 The bench SHALL cover: rst_n low for 1 cycle during RESP, then mem_rvalid=1 -> no rvalid output, all outputs 0, next accept goes to LSU.
